clock_divider_bank: RTL and testbench

// - Parametrised successor to the single seven-segment clock divider: NUM_CH independent dividers off cmosClock.
// - Each channel has a runtime-programmable divisor and emits a one-cycle tick enable plus a 50%-duty divided clock.
// - Feeds display scan and refresh logic (seven-seg digit mux, LED blink, SD status polling) from one block.

---
 rtl/clkdiv_pkg.sv | 20 ++
 rtl/clkdiv_channel.sv | 68 ++++++
 rtl/clock_divider_bank.sv | 116 +++++++++++
 tb/tb_clock_divider_bank.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and sizing helpers for the clock divider bank.
`timescale 1ns/1ps
package clkdiv_pkg;

  localparam int DEFAULT_DIV_W = 18;
  localparam int MAX_CH        = 16;

  typedef logic [DEFAULT_DIV_W-1:0] div_t;

  typedef struct packed {
    logic [$clog2(MAX_CH)-1:0] channel;
    div_t                      divisor;
  } clkdiv_cfg_t;

  // Channel index width, never narrower than one bit so a single channel still has a port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider slice: counter, divisor, tick pulse and 50% divided clock.
// i_at_term selects whether a load applies immediately or waits for the terminal count.
`timescale 1ns/1ps
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W       = DEFAULT_DIV_W,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_at_term,
  input  logic [DIV_W-1:0] i_ld_div,
  output logic             o_tick,
  output logic             o_clk,
  output logic             o_apply
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_tick;
  logic             r_clk;
  logic             w_term;
  logic             w_apply;
  logic             w_load_now;

  assign w_term     = i_en && (r_cnt == r_div);
  assign w_load_now = i_load && !i_at_term;
  // A deferred load lands on the terminal edge, or straight away if the channel is idle.
  assign w_apply    = i_load && (!i_at_term || !i_en || w_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_clk  <= 1'b0;
    end else if (w_load_now) begin
      // Immediate load beats a coincident terminal count: no tick, no toggle.
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_term) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_clk  <= ~r_clk;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= DEFAULT_DIV;
    end else if (w_apply) begin
      r_div <= i_ld_div;
    end
  end

  assign o_tick  = r_tick;
  assign o_clk   = r_clk;
  assign o_apply = w_apply;

endmodule

// File: rtl/clock_divider_bank.sv
// NUM_CH independent programmable dividers with a valid/ready config port.
// Define CLKDIV_SYNC_LOAD_EN for glitch-free divisor updates applied at each channel's terminal count.
`timescale 1ns/1ps
module clock_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          DIV_W       = DEFAULT_DIV_W,
  parameter int unsigned DEFAULT_DIV = 262143
) (
  input  logic                        cmosClock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enable,
  input  logic                        cfgValid,
  output logic                        cfgReady,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfgChannel,
  input  logic [DIV_W-1:0]            cfgDivisor,
  output logic                        cfgError,
  output logic [NUM_CH-1:0]           tickOut,
  output logic [NUM_CH-1:0]           clockOut
);

  localparam int               CH_W    = ch_idx_w(NUM_CH);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

  logic              w_xfer;
  logic              w_oob;
  logic              w_req_valid;
  logic [CH_W-1:0]   w_req_ch;
  logic [DIV_W-1:0]  w_req_div;
  logic              w_at_term;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_apply;
  logic              r_cfg_err;

  assign w_xfer = cfgValid && cfgReady;
  // Widened so the range check stays meaningful when NUM_CH is a power of two.
  assign w_oob  = (32'(cfgChannel) >= NUM_CH);

`ifdef CLKDIV_SYNC_LOAD_EN
  logic             r_pend_valid;
  logic [CH_W-1:0]  r_pend_ch;
  logic [DIV_W-1:0] r_pend_div;

  // Single pending slot: filled by an in-range transfer, emptied when its channel applies it.
  always_ff @(posedge cmosClock) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_div   <= '0;
    end else if (w_xfer && !w_oob) begin
      r_pend_valid <= 1'b1;
      r_pend_ch    <= cfgChannel;
      r_pend_div   <= cfgDivisor;
    end else if (|w_apply) begin
      r_pend_valid <= 1'b0;
    end
  end

  assign cfgReady    = ~r_pend_valid;
  assign w_req_valid = r_pend_valid;
  assign w_req_ch    = r_pend_ch;
  assign w_req_div   = r_pend_div;
  assign w_at_term   = 1'b1;
`else
  logic w_unused_apply;

  assign cfgReady       = 1'b1;
  assign w_req_valid    = w_xfer && !w_oob;
  assign w_req_ch       = cfgChannel;
  assign w_req_div      = cfgDivisor;
  assign w_at_term      = 1'b0;
  assign w_unused_apply = |w_apply;
`endif

  // Decode the active request onto a per-channel load strobe.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_req_ch == CH_W'(i)) begin
        w_load[i] = w_req_valid;
      end else begin
        w_load[i] = 1'b0;
      end
    end
  end

  // Out-of-range transfers complete but only raise a one-cycle error.
  always_ff @(posedge cmosClock) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && w_oob;
    end
  end

  assign cfgError = r_cfg_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (RST_DIV)
    ) u_ch (
      .clk       (cmosClock),
      .rst       (reset),
      .i_en      (enable[g]),
      .i_load    (w_load[g]),
      .i_at_term (w_at_term),
      .i_ld_div  (w_req_div),
      .o_tick    (tickOut[g]),
      .o_clk     (clockOut[g]),
      .o_apply   (w_apply[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank (3 channels, reset divisor 11); follows CLKDIV_SYNC_LOAD_EN when defined.
`timescale 1ns/1ps
module tb_clock_divider_bank;

  logic        cmosClock;
  logic        reset;
  logic [2:0]  enable;
  logic        cfgValid;
  logic        cfgReady;
  logic [1:0]  cfgChannel;
  logic [17:0] cfgDivisor;
  logic        cfgError;
  logic [2:0]  tickOut;
  logic [2:0]  clockOut;

  int n_vec = 0;
  int n_err = 0;

  clock_divider_bank #(
    .NUM_CH      (3),
    .DIV_W       (18),
    .DEFAULT_DIV (11)
  ) dut (
    .cmosClock  (cmosClock),
    .reset      (reset),
    .enable     (enable),
    .cfgValid   (cfgValid),
    .cfgReady   (cfgReady),
    .cfgChannel (cfgChannel),
    .cfgDivisor (cfgDivisor),
    .cfgError   (cfgError),
    .tickOut    (tickOut),
    .clockOut   (clockOut)
  );

  initial cmosClock = 1'b0;
  always #5 cmosClock = ~cmosClock;

  task automatic step();
    @(posedge cmosClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one config beat for exactly one edge; cfgReady is expected high beforehand.
  task automatic do_cfg(input logic [1:0] ch, input logic [17:0] dv);
    chk("cfg_ready_pre", 32'(cfgReady), 32'd1);
    cfgValid   = 1'b1;
    cfgChannel = ch;
    cfgDivisor = dv;
    step();
    cfgValid   = 1'b0;
`ifdef CLKDIV_SYNC_LOAD_EN
    chk("cfg_ready_low", 32'(cfgReady), 32'd0);
    step();
`endif
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 3'b000;
    cfgValid   = 1'b0;
    cfgChannel = 2'd0;
    cfgDivisor = 18'd0;
    step();
    step();
    chk("rst_tick",  32'(tickOut),  32'd0);
    chk("rst_clk",   32'(clockOut), 32'd0);
    chk("rst_err",   32'(cfgError), 32'd0);
    chk("rst_ready", 32'(cfgReady), 32'd1);
    reset = 1'b0;

    // ch0 on reset divisor 11: tick every 12, clock period 24
    enable = 3'b001;
    for (int k = 0; k < 36; k++) begin
      step();
      chk("ch0_tick", 32'(tickOut[0]), 32'(k % 12 == 11));
      chk("ch0_clk",  32'(clockOut[0]), 32'(((k + 1) / 12) % 2));
    end
    chk("ch12_idle", 32'(tickOut[2:1]), 32'd0);
    enable = 3'b000;
    step();
    chk("ch0_dis_tick", 32'(tickOut[0]), 32'd0);
    chk("ch0_dis_hold", 32'(clockOut[0]), 32'd1);
    step(); step(); step();
    chk("ch0_dis_hold2", 32'(clockOut[0]), 32'd1);

    // ch1 div=3: tick every 4, clock period 8
    do_cfg(2'd1, 18'd3);
    chk("cfg_err_none", 32'(cfgError), 32'd0);
    enable = 3'b010;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("ch1_tick", 32'(tickOut[1]), 32'(k % 4 == 3));
      chk("ch1_clk",  32'(clockOut[1]), 32'(((k + 1) / 4) % 2));
    end

`ifdef CLKDIV_SYNC_LOAD_EN
    // div 3->9 captured at edge 16, applied at terminal 19; held second beat (div 4) taken at 20, applied at 29
    cfgValid   = 1'b1;
    cfgChannel = 2'd1;
    cfgDivisor = 18'd9;
    for (int j = 16; j < 40; j++) begin
      step();
      chk("sync_tick", 32'(tickOut[1]),
          32'(j == 19 || j == 29 || j == 34 || j == 39));
      chk("sync_clk", 32'(clockOut[1]),
          32'((j >= 19 && j < 29) || (j >= 34 && j < 39)));
      chk("sync_ready", 32'(cfgReady), 32'(j == 19 || j >= 29));
      if (j == 16) cfgDivisor = 18'd4;
      if (j == 20) cfgValid = 1'b0;
    end
`else
    // div=9 transferred on the very edge ch1 would have ticked: no tick, no toggle
    step(); step(); step();
    cfgValid   = 1'b1;
    cfgChannel = 2'd1;
    cfgDivisor = 18'd9;
    step();
    cfgValid = 1'b0;
    chk("imm_no_glitch_tick", 32'(tickOut[1]), 32'd0);
    chk("imm_no_toggle",      32'(clockOut[1]), 32'd0);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("imm_tick", 32'(tickOut[1]), 32'(j == 10));
      chk("imm_clk",  32'(clockOut[1]), 32'(j == 10));
    end
`endif

    // ch2 div=0: tick stuck high, clock at half rate
    enable = 3'b000;
    step();
    do_cfg(2'd2, 18'd0);
    enable = 3'b100;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ch2_tick", 32'(tickOut[2]), 32'd1);
      chk("ch2_clk",  32'(clockOut[2]), 32'(k % 2 == 0));
    end

    // channel 3 does not exist: error pulse, nothing altered
    cfgValid   = 1'b1;
    cfgChannel = 2'd3;
    cfgDivisor = 18'd5;
    step();
    cfgValid = 1'b0;
    chk("oob_err",      32'(cfgError), 32'd1);
    chk("oob_ready",    32'(cfgReady), 32'd1);
    chk("oob_ch2_tick", 32'(tickOut[2]), 32'd1);
    chk("oob_ch2_clk",  32'(clockOut[2]), 32'd1);
    step();
    chk("oob_err_clr",  32'(cfgError), 32'd0);
    chk("oob_ch2_clk2", 32'(clockOut[2]), 32'd0);

    // ch0 resumes from 0 with its reset divisor still in place
    enable = 3'b101;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("ch0_resume_tick", 32'(tickOut[0]), 32'(k == 11));
      chk("ch0_resume_clk",  32'(clockOut[0]), 32'(k < 11));
    end

    // reset mid-count clears outputs and restores divisors
    step(); step(); step();
    chk("pre_rst_ch2_clk", 32'(clockOut[2]), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_tick",  32'(tickOut),  32'd0);
    chk("mid_rst_clk",   32'(clockOut), 32'd0);
    chk("mid_rst_err",   32'(cfgError), 32'd0);
    chk("mid_rst_ready", 32'(cfgReady), 32'd1);
    reset  = 1'b0;
    enable = 3'b010;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("ch1_rst_div_tick", 32'(tickOut[1]), 32'(k == 11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
